// File: rtl/stream_intf_pkg.sv
// Shared types for the streaming sequencer: FSM state encoding, beat length
// and per-channel configuration record.
package stream_intf_pkg;

  localparam int unsigned SEQ_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stream_seq_state_e;

  typedef logic [SEQ_CNT_W-1:0] seq_len_t;

  typedef struct packed {
    seq_len_t len;
    logic     is_wr;
  } seq_cfg_t;

  function automatic logic seq_is_active(input stream_seq_state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/stream_seq_ctrl_if.sv
// Beat/flow-control bundle between the sequencer (master) and the
// streaming FIFOs / PEA (slave). Names follow the sequencer's point of view.
interface stream_seq_ctrl_if #(
  parameter int unsigned N_DMA_CH = 4
);

  logic [N_DMA_CH-1:0] in_beat_i;
  logic [N_DMA_CH-1:0] out_beat_i;
  logic [N_DMA_CH-1:0] out_full_i;
  logic [N_DMA_CH-1:0] pea_ready_o;
  logic [N_DMA_CH-1:0] in_pop_en_o;

  modport master (
    input  in_beat_i,
    input  out_beat_i,
    input  out_full_i,
    output pea_ready_o,
    output in_pop_en_o
  );

  modport slave (
    output in_beat_i,
    output out_beat_i,
    output out_full_i,
    input  pea_ready_o,
    input  in_pop_en_o
  );

endinterface

// File: rtl/stream_seq_ctrl_beat_cnt.sv
// stream_beat_cnt: per-channel saturating beat counter. done_nxt_o reflects the
// count after this cycle's beat and deliberately ignores clear_i to avoid a loop.
module stream_beat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             beat_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             done_o,
  output logic             done_nxt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             done_s;

  assign done_s     = (len_i == '0) | (cnt_q == len_i);
  assign done_o     = done_s;
  assign done_nxt_o = (len_i == '0) | (cnt_inc_s == len_i);
  assign ovf_o      = beat_i & done_s;

  // Next count: increment only below len, so the counter can never wrap.
  always_comb begin
    cnt_inc_s = cnt_q;
    cnt_d     = cnt_q;
    if (beat_i && (cnt_q < len_i)) begin
      cnt_inc_s = cnt_q + CNT_W'(1);
    end else begin
      cnt_inc_s = cnt_q;
    end
    if (clear_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_inc_s;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stream_seq_ctrl.sv
// Streaming kernel sequencer: counts per-channel beats, drives PEA ready/stall
// and pop enables, pulses done_o. Optional watchdog: STREAM_SEQ_WATCHDOG_EN.
module stream_seq_ctrl
  import stream_intf_pkg::*;
#(
  parameter int unsigned N_DMA_CH = 4,
  parameter int unsigned CNT_W    = SEQ_CNT_W,
  parameter int unsigned WDOG_W   = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [N_DMA_CH-1:0]       reg_dma_ch_type_i,
  input  logic [N_DMA_CH*CNT_W-1:0] reg_len_i,
  stream_seq_ctrl_if.master         strm,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      ovf_err_o,
  output logic                      timeout_o
);

  stream_seq_state_e state_q, state_d;

  logic [N_DMA_CH-1:0][CNT_W-1:0] len_q, len_d;
  logic [N_DMA_CH-1:0]            is_wr_q, is_wr_d;
  logic                           ovf_err_q, ovf_err_d;

  logic [N_DMA_CH-1:0] ch_done_s;
  logic [N_DMA_CH-1:0] ch_done_nxt_s;
  logic [N_DMA_CH-1:0] ch_ovf_s;
  logic [N_DMA_CH-1:0] ch_beat_s;
  logic                active_s;
  logic                start_go_s;
  logic                stall_s;
  logic                rd_done_nxt_s;
  logic                wr_done_nxt_s;
  logic                cnt_clr_s;
  logic                wdog_fire_s;

  assign active_s      = seq_is_active(state_q);
  assign start_go_s    = (state_q == IDLE) & start_i & ~abort_i;
  assign rd_done_nxt_s = &(ch_done_nxt_s | is_wr_q);
  assign wr_done_nxt_s = &(ch_done_nxt_s | ~is_wr_q);
  assign stall_s       = |(is_wr_q & strm.out_full_i & ~ch_done_s);
  assign cnt_clr_s     = (state_d == IDLE);

  // Each channel counts only the beat type matching its direction.
  assign ch_beat_s = {N_DMA_CH{active_s}} &
                     ((is_wr_q & strm.out_beat_i) | (~is_wr_q & strm.in_beat_i));

  for (genvar i = 0; i < N_DMA_CH; i++) begin : g_ch
    stream_beat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (cnt_clr_s),
      .beat_i     (ch_beat_s[i]),
      .len_i      (len_q[i]),
      .done_o     (ch_done_s[i]),
      .done_nxt_o (ch_done_nxt_s[i]),
      .ovf_o      (ch_ovf_s[i])
    );
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_go_s) state_d = RUN;
        else            state_d = IDLE;
      end
      RUN: begin
        if (abort_i || wdog_fire_s)            state_d = IDLE;
        else if (rd_done_nxt_s && wr_done_nxt_s) state_d = DONE;
        else if (rd_done_nxt_s)                state_d = DRAIN;
        else                                   state_d = RUN;
      end
      DRAIN: begin
        if (abort_i || wdog_fire_s) state_d = IDLE;
        else if (wr_done_nxt_s)     state_d = DONE;
        else                        state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Config latch and sticky overflow flag.
  always_comb begin
    len_d     = len_q;
    is_wr_d   = is_wr_q;
    ovf_err_d = ovf_err_q;
    if (start_go_s) begin
      len_d     = reg_len_i;
      is_wr_d   = reg_dma_ch_type_i;
      ovf_err_d = 1'b0;
    end else if (|ch_ovf_s) begin
      ovf_err_d = 1'b1;
    end else begin
      ovf_err_d = ovf_err_q;
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      is_wr_q   <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      is_wr_q   <= is_wr_d;
      ovf_err_q <= ovf_err_d;
    end
  end

`ifdef STREAM_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  assign wdog_fire_s = active_s & (wdog_d == '1);

  // Idle-cycle counter; stalled cycles count too, any beat restarts it.
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (!active_s) begin
      wdog_d = '0;
    end else if ((|strm.in_beat_i) || (|strm.out_beat_i)) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    if (start_go_s) begin
      timeout_d = 1'b0;
    end else if (wdog_fire_s) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wdog_fire_s = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  assign strm.pea_ready_o = {N_DMA_CH{active_s & ~stall_s}};
  assign strm.in_pop_en_o = {N_DMA_CH{(state_q == RUN) & ~stall_s}} & ~is_wr_q & ~ch_done_s;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign ovf_err_o        = ovf_err_q;

endmodule

// File: tb/tb_stream_seq_ctrl.sv
// Directed bench for stream_seq_ctrl; expected done_o cycles are queued when
// stimulus is driven and checked every cycle. Honours STREAM_SEQ_WATCHDOG_EN.
module tb_stream_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [3:0]  reg_dma_ch_type_i = 4'b0000;
  logic [63:0] reg_len_i = 64'd0;
  logic        busy_o, done_o, ovf_err_o, timeout_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sb[$];

  stream_seq_ctrl_if #(.N_DMA_CH(4)) strm ();

  stream_seq_ctrl #(.N_DMA_CH(4), .CNT_W(16), .WDOG_W(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .abort_i           (abort_i),
    .reg_dma_ch_type_i (reg_dma_ch_type_i),
    .reg_len_i         (reg_len_i),
    .strm              (strm.master),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .ovf_err_o         (ovf_err_o),
    .timeout_o         (timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the scoreboard decides whether done_o is due this cycle.
  task automatic tick();
    logic exp_done;
    @(posedge clk);
    #1;
    cyc++;
    exp_done = 1'b0;
    if (sb.size() != 0 && sb[0] == cyc) begin
      exp_done = 1'b1;
      void'(sb.pop_front());
    end
    chk("done_o", done_o, exp_done);
  endtask

  task automatic cfg(input logic [15:0] l3, l2, l1, l0, input logic [3:0] ty);
    reg_len_i         = {l3, l2, l1, l0};
    reg_dma_ch_type_i = ty;
  endtask

  task automatic beats(input logic [3:0] ib, input logic [3:0] ob);
    strm.in_beat_i  = ib;
    strm.out_beat_i = ob;
  endtask

  initial begin
    strm.in_beat_i  = 4'b0000;
    strm.out_beat_i = 4'b0000;
    strm.out_full_i = 4'b0000;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_ready", strm.pea_ready_o, 4'h0);
    chk("rst_pop",   strm.in_pop_en_o, 4'h0);
    chk("rst_busy",  busy_o, 1'b0);
    chk("rst_ovf",   ovf_err_o, 1'b0);
    chk("rst_tmo",   timeout_o, 1'b0);

    // Basic run: reads lead writes by one cycle so DRAIN is visited.
    cfg(16'd8, 16'd8, 16'd8, 16'd8, 4'b1100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("basic_ready", strm.pea_ready_o, 4'hF);
    chk("basic_pop",   strm.in_pop_en_o, 4'b0011);
    for (int k = 0; k < 9; k++) begin
      beats((k < 8) ? 4'b0011 : 4'b0000, (k >= 1) ? 4'b1100 : 4'b0000);
      if (k == 8) sb.push_back(cyc + 1);
      tick();
      if (k == 7) begin
        chk("drain_pop",   strm.in_pop_en_o, 4'b0000);
        chk("drain_ready", strm.pea_ready_o, 4'hF);
      end
    end
    beats(4'b0000, 4'b0000);
    chk("done_ready", strm.pea_ready_o, 4'h0);
    chk("done_busy",  busy_o, 1'b1);
    tick();
    chk("post_busy", busy_o, 1'b0);

    // Backpressure on write channel 2.
    cfg(16'd4, 16'd4, 16'd4, 16'd4, 4'b1100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beats(4'b0011, 4'b1100);
      tick();
    end
    beats(4'b0000, 4'b0000);
    strm.out_full_i = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_ready", strm.pea_ready_o, 4'h0);
      chk("stall_pop",   strm.in_pop_en_o, 4'h0);
    end
    strm.out_full_i = 4'b0000;
    tick();
    chk("unstall_ready", strm.pea_ready_o, 4'hF);
    chk("unstall_pop",   strm.in_pop_en_o, 4'b0011);
    beats(4'b0011, 4'b1100);
    tick();
    chk("bp_busy", busy_o, 1'b1);
    sb.push_back(cyc + 1);
    tick();
    beats(4'b0000, 4'b0000);
    tick();

    // Zero-length / unused channels.
    cfg(16'd0, 16'd3, 16'd0, 16'd3, 4'b1100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("unused_pop", strm.in_pop_en_o, 4'b0001);
      beats(4'b0001, 4'b0100);
      if (k == 2) sb.push_back(cyc + 1);
      tick();
    end
    beats(4'b0000, 4'b0000);
    tick();

    // All lengths zero: done two cycles after start.
    cfg(16'd0, 16'd0, 16'd0, 16'd0, 4'b1100);
    start_i = 1'b1;
    sb.push_back(cyc + 2);
    tick();
    start_i = 1'b0;
    chk("zero_ready", strm.pea_ready_o, 4'hF);
    tick();
    chk("zero_done_ready", strm.pea_ready_o, 4'h0);
    tick();

    // Overflow: a third beat on ch0 after it completed.
    cfg(16'd0, 16'd2, 16'd0, 16'd2, 4'b0100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    beats(4'b0001, 4'b0000);
    tick();
    tick();
    chk("ovf_pre", ovf_err_o, 1'b0);
    tick();
    chk("ovf_set", ovf_err_o, 1'b1);
    beats(4'b0000, 4'b0100);
    tick();
    sb.push_back(cyc + 1);
    tick();
    beats(4'b0000, 4'b0000);
    chk("ovf_sticky", ovf_err_o, 1'b1);
    tick();
    cfg(16'd0, 16'd0, 16'd0, 16'd0, 4'b0000);
    start_i = 1'b1;
    sb.push_back(cyc + 2);
    tick();
    start_i = 1'b0;
    chk("ovf_clr", ovf_err_o, 1'b0);
    tick();
    tick();

    // Abort mid-run.
    cfg(16'd16, 16'd16, 16'd16, 16'd16, 4'b1100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beats(4'b0011, 4'b1100);
      tick();
    end
    beats(4'b0000, 4'b0000);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy",  busy_o, 1'b0);
    chk("abort_ready", strm.pea_ready_o, 4'h0);
    tick();

    // Reset while in DRAIN.
    cfg(16'd4, 16'd4, 16'd1, 16'd1, 4'b1100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    beats(4'b0011, 4'b0000);
    tick();
    chk("rdrain_pop",   strm.in_pop_en_o, 4'h0);
    chk("rdrain_ready", strm.pea_ready_o, 4'hF);
    beats(4'b0001, 4'b0000);
    tick();
    chk("rdrain_ovf", ovf_err_o, 1'b1);
    beats(4'b0000, 4'b0000);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mrst_busy",  busy_o, 1'b0);
    chk("mrst_ready", strm.pea_ready_o, 4'h0);
    chk("mrst_ovf",   ovf_err_o, 1'b0);

    // start and abort together in IDLE.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("sa_busy", busy_o, 1'b0);
    tick();
    chk("sa_busy2", busy_o, 1'b0);

    // No beats at all after start: watchdog or hang-in-RUN.
    cfg(16'd4, 16'd4, 16'd4, 16'd4, 4'b1100);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("wd_busy", busy_o, 1'b1);
    end
    tick();
`ifdef STREAM_SEQ_WATCHDOG_EN
    chk("wd_fire_busy", busy_o, 1'b0);
    chk("wd_tmo",       timeout_o, 1'b1);
    cfg(16'd0, 16'd0, 16'd0, 16'd0, 4'b0000);
    start_i = 1'b1;
    sb.push_back(cyc + 2);
    tick();
    start_i = 1'b0;
    chk("wd_tmo_clr", timeout_o, 1'b0);
    tick();
    tick();
`else
    chk("nowd_busy", busy_o, 1'b1);
    chk("nowd_tmo",  timeout_o, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    chk("nowd_busy2", busy_o, 1'b1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("nowd_abort", busy_o, 1'b0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_seq_ctrl.md
Name: stream_seq_ctrl

Overview:
- Sequences one streaming kernel run through the DMA↔PEA streaming interface.
- Counts per-channel input beats (read-FIFO pops) and output beats (write-FIFO pushes) against programmed lengths.
- Drives the PEA global ready/stall and gates input pops.
- Signals completion once every output stream has drained. Sits between the config register file and the streaming interface/PEA.

Parameters:
- N_DMA_CH, 4, number of DMA channels
- CNT_W, 16, beat counter / length width
- WDOG_W, 12, watchdog counter width (used only with the watchdog macro)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start pulse from config regs
- abort_i  in  1  abort request
- reg_dma_ch_type_i  in  N_DMA_CH  per channel: 1 = write (PEA→DMA), 0 = read (DMA→PEA)
- reg_len_i  in  N_DMA_CH×CNT_W  beats to transfer per channel; 0 = channel unused
- in_beat_i  in  N_DMA_CH  read-FIFO pop accepted this cycle
- out_beat_i  in  N_DMA_CH  write-FIFO push this cycle
- out_full_i  in  N_DMA_CH  write-FIFO full
- pea_ready_o  out  N_DMA_CH  PEA ready/stall per column
- in_pop_en_o  out  N_DMA_CH  permits read-FIFO pop on channel
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse
- ovf_err_o  out  1  sticky: beat received on a completed/unused channel
- timeout_o  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- Reset (rst_i=1 at clk edge): state IDLE, all counters 0. All outputs 0: pea_ready_o, in_pop_en_o, busy_o, done_o, ovf_err_o, timeout_o.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 → RUN. Clears counters, ovf_err_o and timeout_o. Latches reg_len_i and reg_dma_ch_type_i into internal regs; later register changes are ignored until the next start.
- Channel done:
  - ch_done[i] = (latched len[i]==0) | (cnt[i]==len[i]).
  - Read channels count in_beat_i; write channels count out_beat_i.
  - Counter saturates at len. A beat while ch_done[i] sets ovf_err_o and does not increment.
- Stall: stall = OR over write channels i of (out_full_i[i] & ~ch_done[i]).
- pea_ready_o[i] = (state∈{RUN,DRAIN}) & ~stall, identical on all columns (lockstep PEA).
- in_pop_en_o[i] = (state==RUN) & ~stall & read channel & ~ch_done[i].
- busy_o = state∈{RUN,DRAIN,DONE}.
- RUN → DRAIN when all read channels are done, using counts including the current-cycle beat (registered transition; effective next cycle).
- RUN → DONE directly if all read and write channels are done in the same cycle.
- DRAIN → DONE when all write channels are done.
- DONE: done_o=1 for exactly one cycle, pea_ready_o=0, then → IDLE.
- Latency: start_i at cycle t → pea_ready_o high at t+1. Last output beat at t → done_o at t+1.
- All lengths 0: start → RUN → DONE (done_o at t+2), no ready asserted beyond one RUN cycle.
- Arbitration and edge cases:
  - abort_i in any non-IDLE state → IDLE next cycle, counters cleared, no done_o.
  - abort_i and start_i together in IDLE → stays IDLE.
  - start_i while busy is ignored.
  - Reset mid-run wins over everything.
- Counters are unsigned CNT_W bits. Increment is cnt+1 only when cnt<len, so wrap is impossible.

Optional Feature:
- Macro STREAM_SEQ_WATCHDOG_EN.
- Defined:
  - WDOG_W-bit counter increments each RUN/DRAIN cycle with no in_beat_i/out_beat_i bit set; any beat clears it.
  - On reaching all-ones → IDLE, timeout_o set (sticky until next start), no done_o.
  - Stalled cycles (stall=1) also count.
- Undefined: no counter, timeout_o tied 0, and the FSM never leaves RUN/DRAIN except via completion, abort or reset.

Decomposition:
- stream_intf_pkg gains:
  - typedef stream_seq_state_e {IDLE, RUN, DRAIN, DONE}
  - constant SEQ_CNT_W=16
  - typedef seq_len_t logic[SEQ_CNT_W-1:0]
  - typedef seq_cfg_t (per-channel len + type)
- One sub-module: stream_beat_cnt, a per-channel saturating counter. Inputs: clear, beat, len. Outputs: done, ovf. Instantiated N_DMA_CH times.

Test Plan:
- Basic run: ch0,1 read len=8, ch2,3 write len=8. Feed one beat per cycle on all channels → DRAIN after the 8th input beat; done_o exactly 1 cycle after the 8th output beat; busy_o drops the next cycle.
- Backpressure: len=4 all channels; hold out_full_i[2]=1 for 5 cycles mid-run → pea_ready_o and in_pop_en_o all 0 during those cycles; counts unchanged; completes afterwards.
- Zero/unused: lens {3,0,3,0}, types {0,0,1,1} → in_pop_en_o[1]=0 throughout; done after 3 beats on ch0 and ch2. All lengths 0 → done_o 2 cycles after start_i.
- Overflow: ch0 len=2; inject a 3rd in_beat_i → ovf_err_o=1; cnt stays 2; run still completes; flag cleared on next start_i.
- Abort/reset: abort_i at cycle 5 of a len=16 run → IDLE next cycle, no done_o, pea_ready_o=0. rst_i mid-DRAIN → all outputs 0 next cycle. start_i+abort_i together in IDLE → stays IDLE.
- Watchdog (macro on, WDOG_W=4): stop all beats in RUN → after 15 idle cycles state IDLE, timeout_o=1, no done_o. Macro off → remains RUN.
